// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings for the ARM-subset multicycle controller
// Contents: FSM state enum, Op/OpCode/Cond constants, datapath select encodings,
// and small decode helpers used by the controller FSM.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXECR  = 4'd2,
        S_EXECI  = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_LINK   = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_PC        = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    function automatic logic opcode_supported(input logic [3:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_AND) ||
               (opc == OPC_ORR) || (opc == OPC_MOV) || (opc == OPC_CMP);
    endfunction

    function automatic logic [2:0] alu_op(input logic [3:0] opc);
        case (opc)
            OPC_SUB, OPC_CMP: return ALU_SUB;
            OPC_AND:          return ALU_AND;
            OPC_ORR:          return ALU_ORR;
            OPC_MOV:          return ALU_PASSB;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/arm_cond_logic.sv
// rtl/arm_cond_logic.sv - NZCV flag register and condition-code evaluation
// Ports: clk, reset (sync, active-high); cond = Instr[31:28]; alu_flags = ALU NZCV;
// flag_write_nz / flag_write_cv = load enables for {N,Z} and {C,V};
// flags = registered NZCV; cond_ex = instruction passes its condition.
module arm_cond_logic
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_write_nz,
    input  logic       flag_write_cv,
    output logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_write_nz) flags[3:2] <= alu_flags[3:2];
            if (flag_write_cv) flags[1:0] <= alu_flags[1:0];
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // 1111 never executes
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// rtl/arm_multicycle_ctrl.sv - multicycle Moore FSM controller for the ARM-subset core
// Ports: clk, reset (sync, active-high); Instr = IR; ALUFlags = ALU NZCV; MemReady = memory
// handshake. Outputs drive the multicycle datapath enables/muxes; Flags = NZCV register;
// State = current FSM state for debug.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter bit WAIT_MEM  = 1'b1,
    parameter int ALUCTRL_W = 3,
    parameter int LINK_REG  = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic [1:0]           RegSrc,
    output logic                 LinkWrite,
    output logic [3:0]           Flags,
    output logic [3:0]           State
);

    state_t state, next_state;

    logic [3:0] cond, opcode;
    logic [1:0] op;
    logic       imm_bit, s_bit, up_bit, link_bit;
    assign cond     = Instr[31:28];
    assign op       = Instr[27:26];
    assign imm_bit  = Instr[25];
    assign opcode   = Instr[24:21];
    assign link_bit = Instr[24];
    assign up_bit   = Instr[23];
    assign s_bit    = Instr[20];   // also the L bit for memory ops

    // LinkWrite steers WA3 to LINK_REG inside the datapath; the index is not decoded here.
    logic unused_bits;
    assign unused_bits = ^{Instr[19:0], 4'(LINK_REG)};

    logic mem_ready;
    assign mem_ready = WAIT_MEM ? MemReady : 1'b1;

    logic       cond_ex, flag_write_nz, flag_write_cv, is_cmp;
    logic [2:0] alu_ctrl;
    assign is_cmp = (opcode == OPC_CMP);

    arm_cond_logic u_cond_logic (
        .clk           (clk),
        .reset         (reset),
        .cond          (cond),
        .alu_flags     (ALUFlags),
        .flag_write_nz (flag_write_nz),
        .flag_write_cv (flag_write_cv),
        .flags         (Flags),
        .cond_ex       (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = RES_ALUOUT;
        alu_ctrl      = ALU_ADD;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_RD2;
        ImmSrc        = IMM_8;
        RegWrite      = 1'b0;
        RegSrc        = 2'b00;
        LinkWrite     = 1'b0;
        flag_write_nz = 1'b0;
        flag_write_cv = 1'b0;

        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                // PC already advanced, so PC+4 here is PC+8 and readable as R15
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                next_state = S_FETCH;
                if (cond_ex) begin
                    case (op)
                        OP_DP:   if (opcode_supported(opcode))
                                     next_state = imm_bit ? S_EXECI : S_EXECR;
                        OP_MEM:  next_state = S_MEMADR;
                        OP_BR:   next_state = link_bit ? S_LINK : S_BRANCH;
                        default: next_state = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                alu_ctrl = alu_op(opcode);
                if (state == S_EXECI) begin
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_8;
                end
                // Logical ops keep the old carry/overflow
                flag_write_nz = s_bit | is_cmp;
                flag_write_cv = (s_bit | is_cmp) &
                                ((opcode == OPC_ADD) | (opcode == OPC_SUB) | is_cmp);
                next_state    = is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_12;
                alu_ctrl   = up_bit ? ALU_ADD : ALU_SUB;
                next_state = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                RegSrc   = 2'b10;
                MemWrite = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_LINK: begin
                ResultSrc  = RES_PC;
                RegWrite   = 1'b1;
                LinkWrite  = 1'b1;
                next_state = S_BRANCH;
            end
            S_BRANCH: begin
                RegSrc     = 2'b01;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_24;
                ResultSrc  = RES_ALURESULT;
                PCWrite    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // Nothing may be written while reset is held, including a pending flag load
        if (reset) begin
            PCWrite       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            LinkWrite     = 1'b0;
            flag_write_nz = 1'b0;
            flag_write_cv = 1'b0;
        end
    end

    assign ALUControl = ALUCTRL_W'(alu_ctrl);
    assign State      = state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb/tb_arm_multicycle_ctrl.sv - directed self-checking bench for arm_multicycle_ctrl
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, LinkWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  Flags, State;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arm_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .LinkWrite  (LinkWrite),
        .Flags      (Flags),
        .State      (State)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ARM condition table: even codes test a predicate, odd codes its inverse
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    localparam logic [31:0] I_ADDS = 32'hE0921003;
    localparam logic [31:0] I_ANDS = 32'hE0121003;
    localparam logic [31:0] I_MOVI = 32'hE3A01005;
    localparam logic [31:0] I_EOR  = 32'hE0221003;
    localparam logic [31:0] I_CMP  = 32'hE1510002;
    localparam logic [31:0] I_BNE  = 32'h1A000004;
    localparam logic [31:0] I_BEQ  = 32'h0A000004;
    localparam logic [31:0] I_LDR  = 32'hE5921004;
    localparam logic [31:0] I_STR  = 32'hE5821004;
    localparam logic [31:0] I_BL   = 32'hEB000004;

    initial begin
        int cycles;
        int low_left;
        logic [3:0] exp_state;

        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0; MemReady = 1'b1;
        tick(); tick();
        check_eq("rst_state", State, 0);
        check_eq("rst_flags", Flags, 0);
        check_eq("rst_irwrite", IRWrite, 0);
        check_eq("rst_pcwrite", PCWrite, 0);

        // ADDS R1,R2,R3
        reset = 1'b0; Instr = I_ADDS; #1;
        check_eq("adds_fetch_ir", IRWrite, 1);
        check_eq("adds_fetch_pc", PCWrite, 1);
        check_eq("adds_fetch_srcb", ALUSrcB, 2);
        check_eq("adds_fetch_res", ResultSrc, 2);
        check_eq("adds_fetch_rw", RegWrite, 0);
        tick();
        check_eq("adds_dec_state", State, 1);
        check_eq("adds_dec_rw", RegWrite, 0);
        ALUFlags = 4'b0110;
        tick();
        check_eq("adds_exec_state", State, 2);
        check_eq("adds_exec_alu", ALUControl, 0);
        check_eq("adds_exec_rw", RegWrite, 0);
        tick();
        check_eq("adds_wb_state", State, 4);
        check_eq("adds_wb_rw", RegWrite, 1);
        check_eq("adds_wb_res", ResultSrc, 0);
        check_eq("adds_flags", Flags, 4'b0110);
        ALUFlags = 4'b0000;
        tick();
        check_eq("adds_done_state", State, 0);
        check_eq("adds_flags_hold", Flags, 4'b0110);

        // FETCH stall
        MemReady = 1'b0; #1;
        check_eq("stall_ir", IRWrite, 0);
        check_eq("stall_pc", PCWrite, 0);
        tick();
        check_eq("stall_state", State, 0);
        MemReady = 1'b1;

        // ANDS: N,Z from ALU, C,V kept (0110 -> 1010)
        Instr = I_ANDS; ALUFlags = 4'b1001;
        tick(); tick();
        check_eq("ands_alu", ALUControl, 2);
        tick();
        check_eq("ands_flags", Flags, 4'b1010);
        tick();

        // MOV R1,#5 without S: flags untouched
        Instr = I_MOVI; ALUFlags = 4'b1111;
        tick(); tick();
        check_eq("movi_state", State, 3);
        check_eq("movi_alu", ALUControl, 4);
        check_eq("movi_srcb", ALUSrcB, 1);
        check_eq("movi_imm", ImmSrc, 0);
        tick(); tick();
        check_eq("movi_flags", Flags, 4'b1010);
        check_eq("movi_done", State, 0);

        // Unsupported opcode (EOR)
        Instr = I_EOR;
        tick(); tick();
        check_eq("eor_skip", State, 0);

        // CMP sets Z
        Instr = I_CMP; ALUFlags = 4'b0100;
        tick(); tick();
        check_eq("cmp_alu", ALUControl, 1);
        tick();
        check_eq("cmp_done", State, 0);
        check_eq("cmp_flags", Flags, 4'b0100);
        ALUFlags = 4'b0000;

        // BNE not taken
        Instr = I_BNE; #1;
        check_eq("bne_fetch_pc", PCWrite, 1);
        tick();
        check_eq("bne_dec_pc", PCWrite, 0);
        tick();
        check_eq("bne_skip", State, 0);

        // BEQ taken
        Instr = I_BEQ;
        tick(); tick();
        check_eq("beq_state", State, 10);
        check_eq("beq_pc", PCWrite, 1);
        check_eq("beq_imm", ImmSrc, 2);
        check_eq("beq_regsrc", RegSrc, 1);
        check_eq("beq_srca", ALUSrcA, 0);
        tick();
        check_eq("beq_done", State, 0);

        // LDR with three MemReady-low cycles in MEMRD
        Instr = I_LDR; cycles = 0; low_left = 3;
        do begin
            if (State == 4'd6 && low_left > 0) begin
                MemReady = 1'b0;
                low_left--;
            end else begin
                MemReady = 1'b1;
            end
            #1;
            if (State == 4'd5) begin
                check_eq("ldr_adr_alu", ALUControl, 0);
                check_eq("ldr_adr_imm", ImmSrc, 1);
            end
            if (State == 4'd6) check_eq("ldr_rd_adrsrc", AdrSrc, 1);
            if (State == 4'd7) begin
                check_eq("ldr_wb_rw", RegWrite, 1);
                check_eq("ldr_wb_res", ResultSrc, 1);
            end
            tick();
            cycles++;
        end while (State != 4'd0 && cycles < 30);
        check_eq("ldr_cycles", cycles, 8);
        MemReady = 1'b1;

        // BL
        Instr = I_BL;
        tick(); tick();
        check_eq("bl_link_state", State, 9);
        check_eq("bl_linkwrite", LinkWrite, 1);
        check_eq("bl_link_rw", RegWrite, 1);
        check_eq("bl_link_res", ResultSrc, 3);
        tick();
        check_eq("bl_br_state", State, 10);
        check_eq("bl_br_pc", PCWrite, 1);
        check_eq("bl_br_imm", ImmSrc, 2);
        tick();
        check_eq("bl_done", State, 0);

        // STR stalled in MEMWR, then reset mid-instruction
        Instr = I_STR;
        tick(); tick();
        MemReady = 1'b0;
        tick();
        check_eq("str_state", State, 8);
        check_eq("str_memwrite", MemWrite, 1);
        check_eq("str_regsrc", RegSrc, 2);
        check_eq("str_adrsrc", AdrSrc, 1);
        tick();
        check_eq("str_hold", State, 8);
        reset = 1'b1; #1;
        check_eq("str_rst_memwrite", MemWrite, 0);
        tick();
        check_eq("str_rst_state", State, 0);
        check_eq("str_rst_flags", Flags, 0);
        check_eq("str_rst_memwrite2", MemWrite, 0);
        reset = 1'b0; MemReady = 1'b1;

        // All conditions against all flag patterns
        for (int f = 0; f < 16; f++) begin
            Instr = I_CMP; ALUFlags = f[3:0];
            tick(); tick(); tick();
            check_eq($sformatf("sweep_flags_%0d", f), Flags, f);
            for (int c = 0; c < 16; c++) begin
                Instr = {c[3:0], 28'hA000004};
                tick(); tick();
                exp_state = ref_cond(c[3:0], f[3:0]) ? 4'd10 : 4'd0;
                check_eq($sformatf("cond_%0h_flags_%0h", c, f), State, exp_state);
                for (int k = 0; k < 4 && State != 4'd0; k++) tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
